// File: rtl/pipeline_hazard_ctrl.sv
// Load-use, branch-flush and mult/div hold sequencing for the IF/ID and ID/EXE registers.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned MULDIV_CYCLES = 32,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_muldiv,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_br_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idexe_bubble,
  output logic             muldiv_start,
  output logic             muldiv_abort,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned MdW = $clog2(MULDIV_CYCLES + 1);
  localparam logic [MdW-1:0] MdInit = MdW'(MULDIV_CYCLES - 1);

  localparam logic [1:0] StRun    = 2'd0;
  localparam logic [1:0] StMdBusy = 2'd1;
  localparam logic [1:0] StMdDone = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [MdW-1:0] md_cnt_q, md_cnt_d;
  logic           load_use;

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idexe_bubble = 1'b0;
    muldiv_start = 1'b0;
    muldiv_abort = 1'b0;
    muldiv_busy  = (state_q == StMdBusy);
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;

    if (reset) begin
      // Quiet pipeline while in reset; the mult/div unit resets itself, so no abort.
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idexe_bubble = 1'b1;
      muldiv_busy  = 1'b0;
      state_d      = StRun;
      md_cnt_d     = '0;
    end else if (ex_br_taken) begin
      ifid_flush   = 1'b1;
      idexe_bubble = 1'b1;
      muldiv_abort = (state_q != StRun);
      state_d      = StRun;
      md_cnt_d     = '0;
    end else begin
      case (state_q)
        StRun: begin
          if (load_use) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idexe_bubble = 1'b1;
          end else if (id_muldiv) begin
            muldiv_start = 1'b1;
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idexe_bubble = 1'b1;
            md_cnt_d     = MdInit;
            state_d      = StMdBusy;
          end
        end
        StMdBusy: begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idexe_bubble = 1'b1;
          if (md_cnt_q == '0) begin
            state_d = StMdDone;
          end else begin
            md_cnt_d = md_cnt_q - MdW'(1);
          end
        end
        StMdDone: begin
          // Held mult/div moves on to EXE; id_muldiv is deliberately ignored here.
          state_d = StRun;
        end
        default: begin
          state_d  = StRun;
          md_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StRun;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Saturating event counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (ifid_flush && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl against a cycle-level behavioural model.
// Counter expectations follow HAZARD_STATS_EN the same way the design does.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MULDIV_CYCLES = 4;
  localparam int unsigned CNT_W         = 4;
  localparam int          Sat           = (1 << CNT_W) - 1;
  localparam int          NumCycles     = 3000;

  logic             clock;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rs, id_uses_rt, id_muldiv, ex_mem_read, ex_br_taken;
  logic             pc_write, ifid_write, ifid_flush, idexe_bubble;
  logic             muldiv_start, muldiv_abort, muldiv_busy;
  logic [CNT_W-1:0] stall_count, flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl #(
    .MULDIV_CYCLES(MULDIV_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_muldiv   (id_muldiv),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .ex_br_taken (ex_br_taken),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .idexe_bubble(idexe_bubble),
    .muldiv_start(muldiv_start),
    .muldiv_abort(muldiv_abort),
    .muldiv_busy (muldiv_busy),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model state: md_left counts remaining hold cycles of an in-flight mult/div
  // (busy cycles plus the release cycle); 0 means nothing is in flight.
  int md_left = 0;
  int stall_m = 0;
  int flush_m = 0;

  initial begin
    logic lu;
    logic e_pc, e_ifw, e_fl, e_bub, e_st, e_ab, e_busy;
    int   nxt;

    reset       = 1'b1;
    id_rs       = '0;
    id_rt       = '0;
    ex_rt       = '0;
    id_uses_rs  = 1'b0;
    id_uses_rt  = 1'b0;
    id_muldiv   = 1'b0;
    ex_mem_read = 1'b0;
    ex_br_taken = 1'b0;

    for (int cyc = 0; cyc < NumCycles; cyc++) begin
      @(negedge clock);
      reset       = (cyc < 3) || ($urandom_range(0, 99) < 2);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_rt       = 5'($urandom_range(0, 3));
      id_uses_rs  = 1'($urandom_range(0, 1));
      id_uses_rt  = 1'($urandom_range(0, 1));
      ex_mem_read = ($urandom_range(0, 99) < 40);
      id_muldiv   = ($urandom_range(0, 99) < 20);
      ex_br_taken = ($urandom_range(0, 99) < 6);
      #1;

      lu = ex_mem_read && (ex_rt != 0) &&
           ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
      e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_st = 0; e_ab = 0; e_busy = 0;
      nxt = md_left;
      if (reset) begin
        e_pc = 0; e_ifw = 0; e_fl = 1; e_bub = 1;
        nxt = 0;
      end else begin
        e_busy = (md_left > 1);
        if (ex_br_taken) begin
          e_fl = 1; e_bub = 1;
          e_ab = (md_left > 0);
          nxt = 0;
        end else if (md_left > 1) begin
          e_pc = 0; e_ifw = 0; e_bub = 1;
          nxt = md_left - 1;
        end else if (md_left == 1) begin
          nxt = 0;
        end else if (lu) begin
          e_pc = 0; e_ifw = 0; e_bub = 1;
        end else if (id_muldiv) begin
          e_st = 1; e_pc = 0; e_ifw = 0; e_bub = 1;
          nxt = MULDIV_CYCLES + 1;
        end
      end

      check_eq("pc_write",     32'(pc_write),     32'(e_pc));
      check_eq("ifid_write",   32'(ifid_write),   32'(e_ifw));
      check_eq("ifid_flush",   32'(ifid_flush),   32'(e_fl));
      check_eq("idexe_bubble", 32'(idexe_bubble), 32'(e_bub));
      check_eq("muldiv_start", 32'(muldiv_start), 32'(e_st));
      check_eq("muldiv_abort", 32'(muldiv_abort), 32'(e_ab));
      check_eq("muldiv_busy",  32'(muldiv_busy),  32'(e_busy));
      if (cyc > 0) begin
`ifdef HAZARD_STATS_EN
        check_eq("stall_count", 32'(stall_count), 32'(stall_m));
        check_eq("flush_count", 32'(flush_count), 32'(flush_m));
`else
        check_eq("stall_count", 32'(stall_count), 32'(0));
        check_eq("flush_count", 32'(flush_count), 32'(0));
`endif
      end

      @(posedge clock);
      md_left = nxt;
      if (reset) begin
        stall_m = 0;
        flush_m = 0;
      end else begin
        if (!e_pc && stall_m < Sat) stall_m++;
        if (e_fl && flush_m < Sat) flush_m++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
